// File: rtl/voice_adsr_if.sv
// Control and sample bundle between the sequencer front end and one voice_adsr channel.
interface voice_adsr_if #(
  parameter int BITDEPTH = 14
);
  logic [1:0]                 voice_select;
  logic [7:0]                 pulse_width;
  logic [15:0]                pitch_increment;
  logic [7:0]                 envelope_attack;
  logic [7:0]                 envelope_decay;
  logic [7:0]                 envelope_sustain;
  logic [7:0]                 envelope_release;
  logic                       gate;
  logic signed [BITDEPTH-1:0] out;
  logic                       active;

  modport master (
    output voice_select, pulse_width, pitch_increment,
    output envelope_attack, envelope_decay, envelope_sustain, envelope_release,
    output gate,
    input  out, active
  );

  modport slave (
    input  voice_select, pulse_width, pitch_increment,
    input  envelope_attack, envelope_decay, envelope_sustain, envelope_release,
    input  gate,
    output out, active
  );
endinterface

// File: rtl/voice_adsr.sv
// Single synth voice: phase-accumulator oscillator (saw/triangle/pulse/noise) scaled by an ADSR envelope.
// Define VOICE_ADSR_NOISE_EN to build the LFSR noise source; otherwise voice_select 3 is silent.
module voice_adsr #(
  parameter int BITDEPTH    = 14,
  parameter int BITFRACTION = 8,
  parameter int ENVBITS     = 16
) (
  input  logic         sample_clock,
  input  logic         rst,
  voice_adsr_if.slave  bus
);
  localparam int P = BITDEPTH + BITFRACTION;
  localparam logic [ENVBITS-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  logic [P-1:0]                phase;
  logic [BITDEPTH-1:0]         ph;
  logic [BITDEPTH-2:0]         fold;
  logic signed [BITDEPTH-1:0]  wave;
  logic signed [BITDEPTH+ENVBITS:0] prod;
  logic signed [BITDEPTH-1:0]  out_n;
  logic signed [BITDEPTH-1:0]  out_q;
  logic                        active_q;

  state_t                      state, state_n;
  logic [ENVBITS-1:0]          env, env_n;
  logic [ENVBITS-1:0]          sus_lvl;
  logic [ENVBITS:0]            att_step, dec_step, rel_step, att_sum;
  logic                        gate_q, rise, fall;

  assign ph = phase[P-1 -: BITDEPTH];

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) phase <= '0;
    else     phase <= phase + P'(bus.pitch_increment);
  end

`ifdef VOICE_ADSR_NOISE_EN
  logic [15:0] lfsr;
  logic [3:0]  nib_q;

  // LFSR advances whenever the top phase nibble moves, so noise colour tracks pitch
  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      lfsr  <= 16'hACE1;
      nib_q <= '0;
    end else begin
      nib_q <= ph[BITDEPTH-1 -: 4];
      if (ph[BITDEPTH-1 -: 4] != nib_q)
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`endif

  always_comb begin
    wave = '0;
    fold = ph[BITDEPTH-1] ? ~ph[BITDEPTH-2:0] : ph[BITDEPTH-2:0];
    case (bus.voice_select)
      2'd0: wave = {~ph[BITDEPTH-1], ph[BITDEPTH-2:0]};
      2'd1: wave = {~fold[BITDEPTH-2], fold[BITDEPTH-3:0], 1'b0};
      2'd2: wave = (ph[BITDEPTH-1 -: 8] < bus.pulse_width)
                   ? {1'b0, {(BITDEPTH-1){1'b1}}}
                   : {1'b1, {(BITDEPTH-1){1'b0}}};
      default: begin
`ifdef VOICE_ADSR_NOISE_EN
        wave = lfsr[15 -: BITDEPTH];
`else
        wave = '0;
`endif
      end
    endcase
  end

  // Envelope is zero-extended so the product stays signed; >>> floors toward -inf
  always_comb begin
    prod  = wave * $signed({1'b0, env});
    out_n = BITDEPTH'(prod >>> ENVBITS);
  end

  assign rise     = bus.gate & ~gate_q;
  assign fall     = ~bus.gate & gate_q;
  assign sus_lvl  = {bus.envelope_sustain, {(ENVBITS-8){1'b0}}};
  assign att_step = (ENVBITS+1)'(bus.envelope_attack)  + (ENVBITS+1)'(1);
  assign dec_step = (ENVBITS+1)'(bus.envelope_decay)   + (ENVBITS+1)'(1);
  assign rel_step = (ENVBITS+1)'(bus.envelope_release) + (ENVBITS+1)'(1);
  assign att_sum  = {1'b0, env} + att_step;

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      env      <= '0;
      gate_q   <= 1'b0;
      out_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state    <= state_n;
      env      <= env_n;
      gate_q   <= bus.gate;
      out_q    <= out_n;
      active_q <= (state_n != IDLE);
    end
  end

  // A gate edge only changes state; env is carried over so retrigger/release never click
  always_comb begin
    state_n = state;
    env_n   = env;
    if (rise) begin
      state_n = ATTACK;
    end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_n = RELEASE;
    end else begin
      case (state)
        IDLE: env_n = '0;
        ATTACK: begin
          if (att_sum >= {1'b0, ENV_MAX}) begin
            env_n   = ENV_MAX;
            state_n = DECAY;
          end else begin
            env_n = att_sum[ENVBITS-1:0];
          end
        end
        DECAY: begin
          // env - step <= S rewritten as env <= S + step to avoid underflow
          if (env < sus_lvl || {1'b0, env} <= ({1'b0, sus_lvl} + dec_step)) begin
            env_n   = sus_lvl;
            state_n = SUSTAIN;
          end else begin
            env_n = env - dec_step[ENVBITS-1:0];
          end
        end
        SUSTAIN: env_n = sus_lvl;
        RELEASE: begin
          if ({1'b0, env} <= rel_step) begin
            env_n   = '0;
            state_n = IDLE;
          end else begin
            env_n = env - rel_step[ENVBITS-1:0];
          end
        end
        default: begin
          env_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.out    = out_q;
  assign bus.active = active_q;
endmodule

// File: tb/tb_voice_adsr.sv
// Randomized self-checking bench for voice_adsr against an arithmetic reference model.
module tb_voice_adsr;
  localparam int B = 14;
  localparam int F = 8;
  localparam int E = 16;
  localparam int P = B + F;
  localparam int HALF = 1 << (B - 1);
  localparam int FULL = 1 << B;
  localparam int ST_IDLE = 0, ST_ATT = 1, ST_DEC = 2, ST_SUS = 3, ST_REL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  voice_adsr_if #(.BITDEPTH(B)) bus ();

  voice_adsr #(.BITDEPTH(B), .BITFRACTION(F), .ENVBITS(E)) dut (
    .sample_clock (clk),
    .rst          (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  longint m_phase;
  int     m_env, m_st, m_gq, m_lfsr, m_nib, m_out, m_active;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_env    = 0;
    m_st     = ST_IDLE;
    m_gq     = 0;
    m_lfsr   = 16'hACE1;
    m_nib    = 0;
    m_out    = 0;
    m_active = 0;
  endtask

  task automatic model_step();
    int ph, wave, nib, step, s_lvl, mx, fb;
    bit rise, fall;
    ph = int'((m_phase >> F) % (longint'(1) << B));
    case (bus.voice_select)
      2'd0: wave = ph - HALF;
      2'd1: wave = 2 * ((ph < HALF) ? ph : (FULL - 1 - ph)) - HALF;
      2'd2: wave = ((ph >> (B - 8)) < int'(bus.pulse_width)) ? (HALF - 1) : -HALF;
      default: begin
`ifdef VOICE_ADSR_NOISE_EN
        wave = m_lfsr >> (16 - B);
        if (wave >= HALF) wave -= FULL;
`else
        wave = 0;
`endif
      end
    endcase
    m_out = int'((longint'(wave) * longint'(m_env)) >>> E);

    nib = ph >> (B - 4);
    if (nib != m_nib) begin
      fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr = ((m_lfsr << 1) & 16'hFFFF) | fb;
    end
    m_nib = nib;
    m_phase = (m_phase + longint'(bus.pitch_increment)) % (longint'(1) << P);

    mx    = (1 << E) - 1;
    s_lvl = int'(bus.envelope_sustain) << (E - 8);
    rise  = bus.gate && !m_gq;
    fall  = !bus.gate && m_gq;
    if (rise) m_st = ST_ATT;
    else if (fall && m_st inside {ST_ATT, ST_DEC, ST_SUS}) m_st = ST_REL;
    else begin
      case (m_st)
        ST_IDLE: m_env = 0;
        ST_ATT: begin
          step = int'(bus.envelope_attack) + 1;
          if (m_env + step >= mx) begin m_env = mx; m_st = ST_DEC; end
          else m_env += step;
        end
        ST_DEC: begin
          step = int'(bus.envelope_decay) + 1;
          if (m_env - step <= s_lvl || m_env < s_lvl) begin m_env = s_lvl; m_st = ST_SUS; end
          else m_env -= step;
        end
        ST_SUS: m_env = s_lvl;
        default: begin
          step = int'(bus.envelope_release) + 1;
          if (m_env <= step) begin m_env = 0; m_st = ST_IDLE; end
          else m_env -= step;
        end
      endcase
    end
    m_gq = int'(bus.gate);
    m_active = (m_st != ST_IDLE) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    check("out", int'($signed(bus.out)), m_out);
    check("active", int'(bus.active), m_active);
  endtask

  initial begin
    bus.voice_select     = 2'd2;
    bus.pulse_width      = 8'hFF;
    bus.pitch_increment  = 16'h0000;
    bus.envelope_attack  = 8'd255;
    bus.envelope_decay   = 8'd0;
    bus.envelope_sustain = 8'h80;
    bus.envelope_release = 8'd255;
    bus.gate             = 1'b1;
    model_reset();

    // reset held with gate high, then the edge appears on the first free clock
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check("active_after_reset", int'(bus.active), 1);

    // attack to full scale, long decay to 0x8000, sustain, then release to idle
    repeat (256 + 32767 + 20) tick();
    bus.gate = 1'b0;
    repeat (140) tick();
    check("idle_after_release", int'(bus.active), 0);

    // pulse level at near-full envelope across a whole period
    bus.pulse_width      = 8'h80;
    bus.pitch_increment  = 16'h0100;
    bus.envelope_sustain = 8'hFF;
    bus.gate             = 1'b1;
    repeat (16400) tick();

    // retrigger from release at 0x4000
    bus.pitch_increment  = 16'h0000;
    bus.pulse_width      = 8'hFF;
    bus.envelope_sustain = 8'h40;
    bus.envelope_decay   = 8'd255;
    repeat (300) tick();
    bus.gate = 1'b0;
    tick();
    bus.gate = 1'b1;
    repeat (60) tick();

    // asynchronous reset mid-note
    rst = 1'b1;
    #1;
    check("async_rst_out", int'($signed(bus.out)), 0);
    check("async_rst_active", int'(bus.active), 0);
    repeat (2) tick();
    rst = 1'b0;
    bus.envelope_attack = 8'd40;

    // noise select (silent when the noise source is not built)
    bus.voice_select    = 2'd3;
    bus.pitch_increment = 16'h0400;
    repeat (1000) tick();

    // randomized settings and gate activity
    for (int seg = 0; seg < 40; seg++) begin
      bus.voice_select     = 2'($urandom_range(0, 3));
      bus.pulse_width      = 8'($urandom_range(0, 255));
      bus.pitch_increment  = 16'($urandom_range(0, 65535));
      bus.envelope_attack  = 8'($urandom_range(0, 255));
      bus.envelope_decay   = 8'($urandom_range(0, 255));
      bus.envelope_sustain = 8'($urandom_range(0, 255));
      bus.envelope_release = 8'($urandom_range(0, 255));
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 79) == 0) bus.gate = ~bus.gate;
        if ($urandom_range(0, 199) == 0) bus.envelope_sustain = 8'($urandom_range(0, 255));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/voice_adsr.md
# voice_adsr

Single synthesiser voice: phase-accumulator oscillator with four selectable waveforms feeding a full ADSR envelope and an output multiplier, one output sample per `sample_clock`. It is the parametrised successor to the two-stage attack/release voice: it adds sustain level, retrigger without reset, a pulse-width-controlled square, an optional noise source, and a configurable envelope resolution. It sits between the register/sequencer front end and the mixer, and is instantiated once per channel.

## Interface
- `BITDEPTH`, 14, output sample width, two's complement; legal range 8..16.
- `BITFRACTION`, 8, extra fractional phase bits; phase width P = BITDEPTH+BITFRACTION.
- `ENVBITS`, 16, envelope level width; legal range 12..20.
- `sample_clock`  in  1  the only clock; one sample per rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `voice_select`  in  2  0 saw, 1 triangle, 2 pulse, 3 noise.
- `pulse_width`  in  8  pulse duty threshold.
- `pitch_increment`  in  16  phase step per sample, zero-extended to P.
- `envelope_attack`  in  8  attack step = value+1 per sample.
- `envelope_decay`  in  8  decay step = value+1.
- `envelope_sustain`  in  8  sustain level S = {value, ENVBITS-8 zeros}.
- `envelope_release`  in  8  release step = value+1.
- `gate`  in  1  note on (high) / off (low).
- `out`  out  BITDEPTH  registered signed sample.
- `active`  out  1  registered; high when envelope state is not IDLE.

## Operation
- Phase: `phase <= phase + pitch_increment` mod 2^P every clock; 0 holds. ph = phase[P-1 -: BITDEPTH].
- Saw: ph with MSB inverted.
- Triangle: t = ph[B-1] ? ~ph[B-2:0] : ph[B-2:0]; value {t,0} with MSB inverted.
- Pulse: ph[B-1 -: 8] < pulse_width ? +(2^(B-1)-1) : -2^(B-1). pulse_width 0 gives constant low.
- Noise: 16-bit Fibonacci LFSR, shift left, bit0 <= l[15]^l[13]^l[12]^l[10]; steps on every clock where ph[B-1 -: 4] differs from the previous clock's value; sample = l[15 -: B] with MSB as sign.
- Envelope level `env` (ENVBITS, unsigned), max M = 2^ENVBITS-1. States IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
  - Gate rising edge (gate & ~gate_q) from any state -> ATTACK, env kept (no click). Edge takes priority over every other transition that clock.
  - Gate falling edge from ATTACK/DECAY/SUSTAIN -> RELEASE.
  - ATTACK: env += step, saturate; reaching M -> env=M, DECAY.
  - DECAY: if env-step <= S or env < S: env=S, SUSTAIN; else env -= step.
  - SUSTAIN: env <= S every clock (follows live sustain changes).
  - RELEASE: if env <= step: env=0, IDLE; else env -= step.
  - IDLE: env=0; gate held high without an edge does not start a note.
- Output: out <= (wave_signed * {0,env}) >>> ENVBITS, arithmetic, floor.

## Timing
- Reset values: phase 0, LFSR 0xACE1, env 0, state IDLE, gate_q 0, out 0, active 0. Reset mid-note aborts immediately; gate high at reset release produces an edge on the first clock.
- Latency: out at clock n+1 uses phase_n, env_n, voice_select_n; one-cycle register, no pipeline beyond.
- active reflects state after the same edge that updates env.
- Waveform change is glitch-permitted; no phase reset on select change.

## Configuration
- `VOICE_ADSR_NOISE_EN` defined: LFSR and noise waveform built.
- Undefined: no LFSR logic; voice_select 3 yields wave 0, so out stays 0 while the envelope runs normally.

## Test plan
- Reset: rst high 5 clocks with gate=1 -> out 0, active 0; release -> active 1 on the next clock.
- Attack: attack=255, gate rise -> env reaches 65535 and state DECAY exactly 256 clocks after the edge (ENVBITS=16).
- Decay/release: decay=0, sustain=0x80, release=255 -> SUSTAIN at env 0x8000 after 32767 decay clocks; gate low -> IDLE, active 0 after 128 clocks.
- Pulse level: select 2, pulse_width 0x80, increment 0x0100, env 65535 -> out +8190 for 8192 samples then -8192 for 8192 samples.
- Retrigger: gate rise during RELEASE at env 0x4000 -> ATTACK starts from 0x4000, no drop to 0.
- Noise (macro defined): first LFSR step from 0xACE1 -> 0x59C3; macro undefined -> select 3 gives out 0 for 1000 clocks with active 1.
